operand_forward_unit: RTL

//  Parametrised EX-stage forwarding and load-use stall controller for the 5-stage pipeline.

---
 rtl/operand_forward_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/operand_forward_unit.sv
// EX-stage operand forwarding plus load-use stall control with a saturating stall counter.
// Optional one-entry register-file write bypass is enabled by defining OPFWD_RF_BYPASS_EN.
module operand_forward_unit #(
    parameter int DATA_W       = 64,
    parameter int REG_ADDR_W   = 5,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  uses_rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_idex,
    input  logic                  memread_idex,
    input  logic                  regwrite_idex,
    input  logic [REG_ADDR_W-1:0] rs1_idex,
    input  logic [REG_ADDR_W-1:0] rs2_idex,
    input  logic [DATA_W-1:0]     read_data1_idex,
    input  logic [DATA_W-1:0]     read_data2_idex,
    input  logic [REG_ADDR_W-1:0] rd_exmem,
    input  logic                  regwrite_exmem,
    input  logic [DATA_W-1:0]     result_exmem,
    input  logic [REG_ADDR_W-1:0] rd_memwb,
    input  logic                  regwrite_memwb,
    input  logic [DATA_W-1:0]     wb_data_memwb,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [DATA_W-1:0]     operand_a,
    output logic [DATA_W-1:0]     operand_b,
    output logic                  stall,
    output logic                  bubble_idex,
    output logic [CNT_W-1:0]      stall_total
);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG_C  = {REG_ADDR_W{1'b0}};
    localparam logic [3:0]            HOLD_INIT_C = 4'((STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0);
    localparam logic                  MULTI_C     = 1'((STALL_CYCLES > 1) ? 1 : 0);
    localparam logic [CNT_W-1:0]      CNT_MAX_C   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // A producer forwards only when it writes a real (non-x0) register matching the source.
    function automatic logic fwd_match_f(input logic                  wr_en,
                                         input logic [REG_ADDR_W-1:0] rd,
                                         input logic [REG_ADDR_W-1:0] rs);
        return wr_en && (rd != ZERO_REG_C) && (rd == rs);
    endfunction

    logic              ex_hit_a_s, ex_hit_b_s, wb_hit_a_s, wb_hit_b_s;
    logic              byp_hit_a_s, byp_hit_b_s;
    logic [DATA_W-1:0] byp_data_s;
    logic              hazard_s;
    logic              stall_s;
    state_t            state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic [CNT_W-1:0]  stall_total_r;

    assign ex_hit_a_s = fwd_match_f(regwrite_exmem, rd_exmem, rs1_idex);
    assign ex_hit_b_s = fwd_match_f(regwrite_exmem, rd_exmem, rs2_idex);
    assign wb_hit_a_s = fwd_match_f(regwrite_memwb, rd_memwb, rs1_idex);
    assign wb_hit_b_s = fwd_match_f(regwrite_memwb, rd_memwb, rs2_idex);

`ifdef OPFWD_RF_BYPASS_EN
    logic                  byp_valid_r;
    logic [REG_ADDR_W-1:0] byp_rd_r;
    logic [DATA_W-1:0]     byp_data_r;

    // Capture the value retiring to the register file so a same-cycle read can still see it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_valid_r <= 1'b0;
            byp_rd_r    <= ZERO_REG_C;
            byp_data_r  <= {DATA_W{1'b0}};
        end else if (regwrite_memwb && (rd_memwb != ZERO_REG_C)) begin
            byp_valid_r <= 1'b1;
            byp_rd_r    <= rd_memwb;
            byp_data_r  <= wb_data_memwb;
        end
    end

    assign byp_hit_a_s = byp_valid_r && (byp_rd_r == rs1_idex);
    assign byp_hit_b_s = byp_valid_r && (byp_rd_r == rs2_idex);
    assign byp_data_s  = byp_data_r;
`else
    assign byp_hit_a_s = 1'b0;
    assign byp_hit_b_s = 1'b0;
    assign byp_data_s  = {DATA_W{1'b0}};
`endif

    // Operand A source select: EX/MEM beats MEM/WB beats retired bypass beats regfile.
    always_comb begin
        forward_a = 2'b00;
        operand_a = read_data1_idex;
        if (ex_hit_a_s) begin
            forward_a = 2'b10;
            operand_a = result_exmem;
        end else if (wb_hit_a_s) begin
            forward_a = 2'b01;
            operand_a = wb_data_memwb;
        end else if (byp_hit_a_s) begin
            forward_a = 2'b11;
            operand_a = byp_data_s;
        end else begin
            forward_a = 2'b00;
            operand_a = read_data1_idex;
        end
    end

    // Operand B source select, same priority as operand A.
    always_comb begin
        forward_b = 2'b00;
        operand_b = read_data2_idex;
        if (ex_hit_b_s) begin
            forward_b = 2'b10;
            operand_b = result_exmem;
        end else if (wb_hit_b_s) begin
            forward_b = 2'b01;
            operand_b = wb_data_memwb;
        end else if (byp_hit_b_s) begin
            forward_b = 2'b11;
            operand_b = byp_data_s;
        end else begin
            forward_b = 2'b00;
            operand_b = read_data2_idex;
        end
    end

    assign hazard_s = id_valid && memread_idex && regwrite_idex && (rd_idex != ZERO_REG_C) &&
                      ((rd_idex == rs1_id) || (uses_rs2_id && (rd_idex == rs2_id)));

    // Stall sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Stall sequencer next state; hazards seen while holding are absorbed, not re-armed.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        stall_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                stall_s = hazard_s;
                if (hazard_s && MULTI_C) begin
                    state_s = ST_HOLD;
                    cnt_s   = HOLD_INIT_C;
                end else begin
                    state_s = ST_RUN;
                    cnt_s   = cnt_r;
                end
            end
            ST_HOLD: begin
                stall_s = 1'b1;
                if (cnt_r == 4'd0) begin
                    state_s = ST_RUN;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_HOLD;
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = 4'd0;
                stall_s = 1'b0;
            end
        endcase
    end

    // Reset must silence the hazard path immediately, not only after the next edge.
    assign stall       = stall_s & ~reset;
    assign bubble_idex = stall_s & ~reset;

    // Saturating stalled-cycle counter for performance monitoring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_total_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_total_r != CNT_MAX_C)) begin
            stall_total_r <= stall_total_r + CNT_ONE_C;
        end
    end

    assign stall_total = stall_total_r;

endmodule
